// File: rtl/dotp_pipe_arbiter.sv
// Round-robin arbiter and issue controller sharing one two-stage dot-product pipeline
// (C = A1*B1 + A2*B2) between two requesters. Results are tagged with the requester ID.
// Latency: grant is zero-cycle; the result is returned LAT cycles after the issue edge.
// Backpressure: ready depends only on valid, en, rst_n and prio. Responses have no backpressure.
//
// Ports:
//   clk, rst_n               clock shared with the pipeline; synchronous active-low reset
//   en                       issue enable; operations already in flight still complete
//   reqN_valid / reqN_ready  per-requester handshake (valid & ready at a rising edge)
//   reqN_a1/a2/b1/b2         per-requester operand set
//   pipe_A1/A2/B1/B2         operands to the shared pipeline (0 when nothing is granted)
//   pipe_C                   result from the shared pipeline
//   rsp_valid/rsp_id/rsp_data  tagged result; data is forced to 0 when not valid
//   idle                     nothing in flight and nothing granted this cycle
module dotp_pipe_arbiter #(
   parameter int WIDTH = 32,
   parameter int LAT   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a1,
   input  logic [WIDTH-1:0] req0_a2,
   input  logic [WIDTH-1:0] req0_b1,
   input  logic [WIDTH-1:0] req0_b2,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a1,
   input  logic [WIDTH-1:0] req1_a2,
   input  logic [WIDTH-1:0] req1_b1,
   input  logic [WIDTH-1:0] req1_b2,
   output logic [WIDTH-1:0] pipe_A1,
   output logic [WIDTH-1:0] pipe_A2,
   output logic [WIDTH-1:0] pipe_B1,
   output logic [WIDTH-1:0] pipe_B2,
   input  logic [WIDTH-1:0] pipe_C,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             idle
);

   // Priority: which requester wins when both are valid.
   logic prio_q, prio_d;

   // In-flight tracker: bit i describes the op issued i+1 edges ago.
   logic [LAT-1:0] v_q, v_d;
   logic [LAT-1:0] id_q, id_d;

   // Grant signals.
   logic gnt_ok;
   logic gnt0, gnt1;
   logic issue;
   logic issue_id;

   // Shift staging vectors; the extra LSB carries the new entry in, which keeps the
   // shift well-formed even when LAT is 1.
   logic [LAT:0] v_ext;
   logic [LAT:0] id_ext;

   // ------------------------------------------------------------------
   // Grant logic. Readys are gated by rst_n so nothing can issue during reset.
   // ------------------------------------------------------------------
   always_comb begin
      gnt_ok = en & rst_n;
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      if (gnt_ok) begin
         if (req0_valid && req1_valid) begin
            gnt0 = ~prio_q;
            gnt1 = prio_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // A grant is only raised toward a valid requester, so any grant is a handshake.
   assign issue    = gnt0 | gnt1;
   assign issue_id = gnt1;

   // ------------------------------------------------------------------
   // Operand mux toward the shared pipeline.
   // ------------------------------------------------------------------
   always_comb begin
      pipe_A1 = '0;
      pipe_A2 = '0;
      pipe_B1 = '0;
      pipe_B2 = '0;
      if (gnt0) begin
         pipe_A1 = req0_a1;
         pipe_A2 = req0_a2;
         pipe_B1 = req0_b1;
         pipe_B2 = req0_b2;
      end else if (gnt1) begin
         pipe_A1 = req1_a1;
         pipe_A2 = req1_a2;
         pipe_B1 = req1_b1;
         pipe_B2 = req1_b2;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic.
   // ------------------------------------------------------------------
   always_comb begin
      // Strict alternation under contention: the winner hands priority to the other side.
      prio_d = prio_q;
      if (issue) begin
         prio_d = ~issue_id;
      end

      v_ext  = {v_q, issue};
      id_ext = {id_q, issue_id};
      v_d    = v_ext[LAT-1:0];
      id_d   = id_ext[LAT-1:0];
   end

   // Reset clears the tracker, so ops still inside the pipeline registers are never
   // reported even though the pipeline itself is not reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
         v_q    <= '0;
         id_q   <= '0;
      end else begin
         prio_q <= prio_d;
         v_q    <= v_d;
         id_q   <= id_d;
      end
   end

   // ------------------------------------------------------------------
   // Response and status.
   // ------------------------------------------------------------------
   assign rsp_valid = v_q[LAT-1];
   assign rsp_id    = id_q[LAT-1];
   assign rsp_data  = v_q[LAT-1] ? pipe_C : '0;
   assign idle      = ~(|v_q) & ~issue;

endmodule
